// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, the control
// FSM state type and small width-independent decode helpers.
package alu_pkg;

    // Opcode encodings carried on cu_aluc.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_MULU = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    // True when the request needs the iterative unit. A divide by zero is
    // resolved in one cycle and never enters the iterative path.
    function automatic logic is_iter_op(input logic [3:0] op, input logic divisor_zero);
        return (op == ALU_MULU) || ((op == ALU_DIVU) && !divisor_zero);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply / divide datapath, one bit per cycle.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   start       - load operands and begin (op: 0 = multiply, 1 = divide)
//   a, b        - operands (multiplicand/multiplier or dividend/divisor)
//   done        - high during the final iteration cycle
//   lo, hi      - values after the current iteration; when done is high these
//                 are product low/high or quotient/remainder
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic             active_r;
    logic             op_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_r;    // partial product high word / partial remainder
    logic [WIDTH-1:0] q_r;      // multiplier shifting into product low / dividend into quotient
    logic [WIDTH-1:0] b_r;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rsh_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;
    logic [WIDTH-1:0] acc_n_s;
    logic [WIDTH-1:0] q_n_s;

    // One shift-add or restoring-divide step on the current registers.
    always_comb begin
        sum_s  = {1'b0, acc_r} + (q_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        rsh_s  = {acc_r, q_r[WIDTH-1]};
        ge_s   = (rsh_s >= {1'b0, b_r});
        // When ge_s holds the true difference is below b_r, so the low bits suffice.
        diff_s = rsh_s[WIDTH-1:0] - b_r;
        if (op_r) begin
            acc_n_s = ge_s ? diff_s : rsh_s[WIDTH-1:0];
            q_n_s   = {q_r[WIDTH-2:0], ge_s};
        end else begin
            acc_n_s = sum_s[WIDTH:1];
            q_n_s   = {sum_s[0], q_r[WIDTH-1:1]};
        end
    end

    assign done = active_r && (cnt_r == CW'(WIDTH - 1));
    assign lo   = q_n_s;
    assign hi   = acc_n_s;

    // Operand load on start, then one iteration per cycle until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            op_r     <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            q_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
        end else if (start) begin
            active_r <= 1'b1;
            op_r     <= op;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            q_r      <= a;
            b_r      <= b;
        end else if (active_r) begin
            acc_r <= acc_n_s;
            q_r   <= q_n_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (done) begin
                active_r <= 1'b0;
            end else begin
                active_r <= 1'b1;
            end
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with valid/ready handshake and registered result.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid / in_ready  - request handshake (accepted only in IDLE)
//   alu_ra, alu_rb       - operands, cu_aluc - opcode
//   out_valid/out_ready  - result handshake (held in DONE until taken)
//   alu_result, alu_hi   - result and high word / remainder, alu_zero - result is 0
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_ra,
    input  logic [WIDTH-1:0] alu_rb,
    input  logic [3:0]       cu_aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_hi,
    output logic             alu_zero
);

    localparam int SW = $clog2(WIDTH);

    alu_state_t       state_r;
    alu_state_t       state_n;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] hi_r;
    logic             zero_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             rb_zero_s;
    logic             accept_s;
    logic             start_s;
    logic [SW-1:0]    sh_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [WIDTH-1:0] alu_hi_s;
    logic [WIDTH-1:0] res_n_s;
    logic [WIDTH-1:0] hi_n_s;
    logic             mdu_done_s;
    logic [WIDTH-1:0] mdu_lo_s;
    logic [WIDTH-1:0] mdu_hi_s;

    assign rb_zero_s = (alu_rb == {WIDTH{1'b0}});
    assign accept_s  = (state_r == ST_IDLE) && in_valid;
    assign start_s   = accept_s && is_iter_op(cu_aluc, rb_zero_s);
    assign sh_s      = alu_rb[SW-1:0];

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s),
        .op    (cu_aluc == ALU_DIVU),
        .a     (alu_ra),
        .b     (alu_rb),
        .done  (mdu_done_s),
        .lo    (mdu_lo_s),
        .hi    (mdu_hi_s)
    );

    // Single-cycle ALU, including the divide-by-zero shortcut.
    always_comb begin
        alu_hi_s = {WIDTH{1'b0}};
        case (cu_aluc)
            ALU_ADD:  alu_res_s = alu_ra + alu_rb;
            ALU_SUB:  alu_res_s = alu_ra - alu_rb;
            ALU_AND:  alu_res_s = alu_ra & alu_rb;
            ALU_OR:   alu_res_s = alu_ra | alu_rb;
            ALU_XOR:  alu_res_s = alu_ra ^ alu_rb;
            ALU_SLL:  alu_res_s = alu_ra << sh_s;
            ALU_SRL:  alu_res_s = alu_ra >> sh_s;
            ALU_SRA:  alu_res_s = $unsigned($signed(alu_ra) >>> sh_s);
            ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(alu_ra) < $signed(alu_rb))};
            ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (alu_ra < alu_rb)};
            ALU_DIVU: begin
                // Only reaches the output when the divisor is zero.
                alu_res_s = {WIDTH{1'b1}};
                alu_hi_s  = alu_ra;
            end
            default:  alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_n = ST_IDLE;
                end else if (cu_aluc == ALU_MULU) begin
                    state_n = ST_MUL;
                end else if (start_s) begin
                    state_n = ST_DIV;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (mdu_done_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = state_r;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Next output values: loaded only on the transition into DONE, held otherwise.
    always_comb begin
        res_n_s = result_r;
        hi_n_s  = hi_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !start_s) begin
                    res_n_s = alu_res_s;
                    hi_n_s  = alu_hi_s;
                end else begin
                    res_n_s = result_r;
                    hi_n_s  = hi_r;
                end
            end
            ST_MUL, ST_DIV: begin
                if (mdu_done_s) begin
                    res_n_s = mdu_lo_s;
                    hi_n_s  = mdu_hi_s;
                end else begin
                    res_n_s = result_r;
                    hi_n_s  = hi_r;
                end
            end
            default: begin
                res_n_s = result_r;
                hi_n_s  = hi_r;
            end
        endcase
    end

    // Output and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            result_r    <= res_n_s;
            hi_r        <= hi_n_s;
            zero_r      <= (res_n_s == {WIDTH{1'b0}});
            in_ready_r  <= (state_n == ST_IDLE);
            out_valid_r <= (state_n == ST_DONE);
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign alu_result = result_r;
    assign alu_hi     = hi_r;
    assign alu_zero   = zero_r;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu with a behavioural reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] alu_ra;
    logic [W-1:0] alu_rb;
    logic [3:0]   cu_aluc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic [W-1:0] alu_hi;
    logic         alu_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ra     (alu_ra),
        .alu_rb     (alu_rb),
        .cu_aluc    (cu_aluc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .alu_hi     (alu_hi),
        .alu_zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the opcode definitions.
    task automatic ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [31:0] h, output int lat);
        logic [63:0] p;
        logic [4:0]  s;
        s   = b[4:0];
        h   = 32'd0;
        lat = 1;
        case (o)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << s;
            4'd6:  r = a >> s;
            4'd7:  r = $unsigned($signed(a) >>> s);
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd12: begin
                p   = {32'd0, a} * {32'd0, b};
                r   = p[31:0];
                h   = p[63:32];
                lat = 33;
            end
            4'd13: begin
                if (b == 32'd0) begin
                    r = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    r   = a / b;
                    h   = a % b;
                    lat = 33;
                end
            end
            default: r = 32'd0;
        endcase
    endtask

    // Wait for in_ready, present one request and complete the accept edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int waited;
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_value("ready_before_issue", in_ready, 1);
        in_valid = 1'b1;
        alu_ra   = a;
        alu_rb   = b;
        cu_aluc  = o;
        @(posedge clk);
        #1;
        // Scramble the operand bus: the DUT must use its latched copies.
        in_valid = 1'b0;
        alu_ra   = $urandom;
        alu_rb   = $urandom;
        cu_aluc  = 4'($urandom);
    endtask

    // Full transaction: issue, measure latency, check, hold under backpressure, retire.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic [31:0] eh;
        int          el;
        int          n;
        bit          seen;
        ref_op(o, a, b, er, eh, el);
        out_ready = 1'b0;
        issue(o, a, b);
        n    = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1;
            else check_value("busy_in_ready", in_ready, 0);
        end
        check_value("latency", n, el);
        check_value("result", alu_result, er);
        check_value("hi", alu_hi, eh);
        check_value("zero", alu_zero, (er == 32'd0));
        check_value("done_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            cu_aluc  = 4'($urandom);
            alu_ra   = $urandom;
            alu_rb   = $urandom;
            @(negedge clk);
            check_value("hold_valid", out_valid, 1);
            check_value("hold_result", alu_result, er);
            check_value("hold_hi", alu_hi, eh);
            check_value("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_value("retire_in_ready", in_ready, 1);
        check_value("retire_out_valid", out_valid, 0);
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          r;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ra    = 32'd0;
        alu_rb    = 32'd0;
        cu_aluc   = 4'd0;
        repeat (3) @(negedge clk);
        check_value("rst_in_ready", in_ready, 1);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_result", alu_result, 0);
        check_value("rst_hi", alu_hi, 0);
        check_value("rst_zero", alu_zero, 1);
        rst_n = 1'b1;

        // Directed cases from the test plan.
        run_op(4'b0000, 32'h0000_000F, 32'h8000_000C, 0);
        run_op(4'b0001, 32'h0000_000F, 32'h0000_000F, 0);
        run_op(4'b1000, 32'h0000_000F, 32'h8000_000C, 0);
        run_op(4'b1001, 32'h0000_000F, 32'h8000_000C, 0);
        run_op(4'b0111, 32'h8000_000C, 32'h0000_0004, 0);
        run_op(4'b1100, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        run_op(4'b1101, 32'd100, 32'd7, 0);
        run_op(4'b1101, 32'd5, 32'd0, 0);
        run_op(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(4'b0000, 32'h0000_0001, 32'h0000_0002, 10);
        run_op(4'b1100, 32'h8765_4321, 32'hFEDC_BA98, 10);

        // Reset in the middle of a divide aborts it.
        issue(4'b1101, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("abort_out_valid", out_valid, 0);
        check_value("abort_result", alu_result, 0);
        check_value("abort_in_ready", in_ready, 1);
        check_value("abort_zero", alu_zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'b0000, 32'h0000_0010, 32'h0000_0020, 0);

        // Randomized traffic, biased toward the iterative operations.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 21);
            if (r >= 16) o = (r[0]) ? 4'd12 : 4'd13;
            else         o = 4'(r);
            a = $urandom;
            b = $urandom;
            if (o == 4'd13 && $urandom_range(0, 3) == 0) b = 32'd0;
            if (o == 4'd13 && $urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 30);
            run_op(o, a, b, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
